uart_rx: RTL and testbench

Serial receiver for the team's UART: the receive-side counterpart of `UART_TX`, sharing its 8N1 frame format and 16-bit `baud_rate_control` convention. It watches `data_line`, synchronises it, and detects and validates the start bit. It then samples eight data bits LSB-first at mid-bit and checks the stop bit. The received byte is presented on `read_buffer` with a ready/acknowledge handshake to the host logic.

---
 rtl/uart_rx_pkg.sv | 9 +
 rtl/uart_rx_if.sv | 12 +
 rtl/uart_rx_sync.sv | 15 +
 rtl/uart_rx.sv | 88 ++++++++
 tb/tb_uart_rx.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART frame constants, receiver states and divider clamp.
package uart_rx_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam logic [15:0] UART_MIN_DIV = 16'd4;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_e;
  function automatic logic [15:0] clamp_div(input logic [15:0] n);
    return (n < UART_MIN_DIV) ? UART_MIN_DIV : n;
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte handshake and status between receiver and host.
interface uart_rx_if;
  import uart_rx_pkg::*;
  logic [UART_DATA_BITS-1:0] read_buffer;
  logic data_ready;
  logic read_ack;
  logic frame_error;
  logic overrun;
  logic busy;
  modport master (output read_buffer, data_ready, frame_error, overrun, busy, input read_ack);
  modport slave (input read_buffer, data_ready, frame_error, overrun, busy, output read_ack);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_sync: multi-stage synchroniser for an asynchronous input with a chosen reset value.
module uart_sync #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk)
    sync_q <= reset ? {STAGES{RST_VAL}} : {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, frame-error and overrun reporting.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_line,
  input  logic [15:0] baud_rate_control,
  uart_rx_if.master   bus
);
  rx_state_e state_q;
  logic [15:0] cnt_q, n_lat_q;
  logic [2:0] bit_idx_q;
  logic [DATA_BITS-1:0] shift_q, buf_q;
  logic data_ready_q, frame_error_q, overrun_q, busy_q, rx_s;
  uart_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk(clk), .reset(reset), .d_i(data_line), .q_o(rx_s)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      n_lat_q <= UART_MIN_DIV;
      bit_idx_q <= '0;
      shift_q <= '0;
      buf_q <= '0;
      data_ready_q <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      frame_error_q <= 1'b0;
      cnt_q <= cnt_q + 16'd1;
      if (bus.read_ack) begin
        data_ready_q <= 1'b0;
        overrun_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (!rx_s) begin
          n_lat_q <= clamp_div(baud_rate_control);
          cnt_q <= '0;
          busy_q <= 1'b1;
          state_q <= START;
        end
        START: if (cnt_q == (n_lat_q >> 1) - 16'd1) begin
          cnt_q <= '0;
          bit_idx_q <= '0;
          busy_q <= ~rx_s;
          state_q <= rx_s ? IDLE : DATA;
        end
        DATA: if (cnt_q == n_lat_q - 16'd1) begin
          cnt_q <= '0;
          shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
          bit_idx_q <= bit_idx_q + 3'd1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) state_q <= STOP;
        end
        STOP: if (cnt_q == n_lat_q - 16'd1) begin
          cnt_q <= '0;
          if (rx_s) begin
            // completion beats a same-cycle ack; an acked old byte is not an overrun
            buf_q <= shift_q;
            data_ready_q <= 1'b1;
            overrun_q <= bus.read_ack ? 1'b0 : (overrun_q | data_ready_q);
            busy_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            frame_error_q <= 1'b1;
            state_q <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: if (rx_s) begin
          cnt_q <= '0;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.read_buffer = buf_q;
  assign bus.data_ready = data_ready_q;
  assign bus.frame_error = frame_error_q;
  assign bus.overrun = overrun_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames checked against a byte-level receiver model.
module tb_uart_rx;
  localparam int SYNC = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data_line = 1'b1;
  logic [15:0] baud = 16'd16;
  logic abort_tx = 1'b0;
  int total = 0, bad = 0;
  int cyc = 0, fe_cnt = 0, busy_cnt = 0, rise_cyc = 0, start_cyc = 0;
  logic dr_prev = 1'b0;
  logic [7:0] m_rb = 8'h00;
  logic m_dr = 1'b0, m_ov = 1'b0;
  uart_rx_if bus();
  uart_rx dut (
    .clk(clk), .reset(reset), .data_line(data_line),
    .baud_rate_control(baud), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.frame_error) fe_cnt++;
    if (bus.busy) busy_cnt++;
    if (bus.data_ready && !dr_prev) rise_cyc = cyc;
    dr_prev = bus.data_ready;
  end
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_model(input string tag);
    check({tag, ".read_buffer"}, 16'(bus.read_buffer), 16'(m_rb));
    check({tag, ".data_ready"}, 16'(bus.data_ready), 16'(m_dr));
    check({tag, ".overrun"}, 16'(bus.overrun), 16'(m_ov));
  endtask
  function automatic void model_complete(input logic [7:0] b, input logic acked);
    m_ov = acked ? 1'b0 : (m_ov | m_dr);
    m_dr = 1'b1;
    m_rb = b;
  endfunction
  function automatic int frame_latency(input int n);
    return SYNC + 1 + n / 2 + 9 * n;
  endfunction
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic ack();
    @(negedge clk) bus.read_ack = 1'b1;
    @(negedge clk) bus.read_ack = 1'b0;
    m_dr = 1'b0;
    m_ov = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] b, input int n, input logic stop_v, input int stop_len);
    for (int i = 0; i < 9; i++)
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        if (abort_tx) begin
          data_line = 1'b1;
          return;
        end
        if (i == 0 && c == 0) start_cyc = cyc;
        data_line = (i == 0) ? 1'b0 : b[i-1];
      end
    for (int c = 0; c < stop_len; c++) begin
      @(negedge clk);
      data_line = stop_v;
    end
    @(negedge clk) data_line = 1'b1;
  endtask
  initial begin
    int fe0, busy0, n_eff, nb;
    logic [7:0] b;
    bus.read_ack = 1'b0;
    idle(3);
    check("reset.read_buffer", 16'(bus.read_buffer), 16'h0);
    check("reset.data_ready", 16'(bus.data_ready), 16'h0);
    check("reset.frame_error", 16'(bus.frame_error), 16'h0);
    check("reset.overrun", 16'(bus.overrun), 16'h0);
    check("reset.busy", 16'(bus.busy), 16'h0);
    reset = 1'b0;
    idle(5);
    fe0 = fe_cnt;
    send_frame(8'hA5, 16, 1'b1, 16);
    model_complete(8'hA5, 1'b0);
    check_model("a5");
    check("a5.latency", 16'(rise_cyc - start_cyc), 16'(frame_latency(16)));
    check("a5.frame_error", 16'(fe_cnt - fe0), 16'h0);
    ack();
    check_model("a5_ack");
    idle(5);
    busy0 = busy_cnt;
    @(negedge clk) data_line = 1'b0;
    idle(3);
    data_line = 1'b1;
    idle(40);
    check("glitch.data_ready", 16'(bus.data_ready), 16'h0);
    check("glitch.busy_range", 16'((busy_cnt - busy0) >= 6 && (busy_cnt - busy0) <= 9), 16'h1);
    check("glitch.busy_now", 16'(bus.busy), 16'h0);
    fe0 = fe_cnt;
    send_frame(8'h3C, 16, 1'b0, 32);
    check("ferr.still_busy", 16'(bus.busy), 16'h1);
    idle(6);
    check("ferr.pulses", 16'(fe_cnt - fe0), 16'h1);
    check("ferr.busy_released", 16'(bus.busy), 16'h0);
    check_model("ferr");
    send_frame(8'h81, 16, 1'b1, 16);
    model_complete(8'h81, 1'b0);
    check_model("after_ferr_81");
    ack();
    send_frame(8'h11, 16, 1'b1, 16);
    model_complete(8'h11, 1'b0);
    send_frame(8'h22, 16, 1'b1, 16);
    model_complete(8'h22, 1'b0);
    check_model("overrun");
    ack();
    check_model("overrun_ack");
    send_frame(8'h66, 16, 1'b1, 16);
    model_complete(8'h66, 1'b0);
    fork
      send_frame(8'h77, 16, 1'b1, 16);
      begin
        @(negedge clk);
        repeat (frame_latency(16) - 1) @(negedge clk);
        bus.read_ack = 1'b1;
        @(negedge clk) bus.read_ack = 1'b0;
      end
    join
    model_complete(8'h77, 1'b1);
    check_model("same_cycle_ack");
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(1) == 1) ack();
      nb = int'($urandom_range(20));
      n_eff = (nb < 4) ? 4 : nb;
      b = 8'($urandom);
      baud = 16'(nb);
      busy0 = int'(m_dr);
      fork
        send_frame(b, n_eff, 1'b1, n_eff);
        begin
          repeat (15) @(negedge clk);
          baud = 16'($urandom);
        end
      join
      model_complete(b, 1'b0);
      check_model($sformatf("rand%0d", k));
      if (busy0 == 0)
        check($sformatf("rand%0d.latency", k), 16'(rise_cyc - start_cyc), 16'(frame_latency(n_eff)));
      idle(int'($urandom_range(5)));
    end
    baud = 16'd8;
    fork
      send_frame(8'hF0, 8, 1'b1, 8);
      begin
        @(negedge clk);
        repeat (44) @(negedge clk);
        abort_tx = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check("midreset.read_buffer", 16'(bus.read_buffer), 16'h0);
        check("midreset.data_ready", 16'(bus.data_ready), 16'h0);
        check("midreset.overrun", 16'(bus.overrun), 16'h0);
        check("midreset.frame_error", 16'(bus.frame_error), 16'h0);
        check("midreset.busy", 16'(bus.busy), 16'h0);
        reset = 1'b0;
      end
    join
    abort_tx = 1'b0;
    m_rb = 8'h00;
    m_dr = 1'b0;
    m_ov = 1'b0;
    idle(20);
    check_model("post_reset_idle");
    send_frame(8'h0F, 8, 1'b1, 8);
    model_complete(8'h0F, 1'b0);
    check_model("post_reset_0f");
    check("post_reset.latency", 16'(rise_cyc - start_cyc), 16'(frame_latency(8)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
